div32_seq: RTL

- Iterative 32-bit signed/unsigned integer divider; the inverse operation of the team's combinational 32-bit multiplier.
- Restoring shift-subtract, one quotient bit per clock.
- Sits beside the multiplier in the ALU datapath and serves the DIV/DIVU instructions.
- Returns quotient and remainder with a START/DONE handshake.

---
 rtl/div32_seq_pkg.sv | 20 ++
 rtl/div32_seq_if.sv | 26 ++
 rtl/div32_seq_div_restore_step.sv | 35 +++
 rtl/div32_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/div32_seq_pkg.sv
// Shared definitions for the div32_seq iterative divider: state encoding,
// iteration count, div-by-zero quotient and the two's-complement helper.
package div32_seq_pkg;

    localparam int DIV_W    = 32;
    localparam int DIV_ITER = 32;
    localparam int CNT_W    = 6;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic [31:0] twoscomp32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/div32_seq_if.sv
// START/DONE request and result bundle between the ALU issue logic (master)
// and the divider (slave).
interface div32_seq_if;
    import div32_seq_pkg::*;

    logic             start;
    logic             signed_mode;
    logic [DIV_W-1:0] a;
    logic [DIV_W-1:0] b;
    logic             busy;
    logic             done;
    logic [DIV_W-1:0] q;
    logic [DIV_W-1:0] r;
    logic             div_zero;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, q, r, div_zero
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, q, r, div_zero
    );

endinterface

// File: rtl/div32_seq_div_restore_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and trial-subtract the divisor with a ripple subtractor.
module div32_seq_div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   subtr_s;
    logic [WIDTH-1:0] diff_s;
    logic             carry_s;

    assign shifted_s = {rem_i, dvd_bit_i};
    assign subtr_s   = ~{1'b0, dsr_i};

    // Ripple add of the inverted divisor plus one; final carry-out set means no borrow.
    always_comb begin
        carry_s = 1'b1;
        diff_s  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            diff_s[i] = shifted_s[i] ^ subtr_s[i] ^ carry_s;
            carry_s   = (shifted_s[i] & subtr_s[i]) | (carry_s & (shifted_s[i] ^ subtr_s[i]));
        end
        q_bit_o = (shifted_s[WIDTH] & subtr_s[WIDTH]) |
                  (carry_s & (shifted_s[WIDTH] ^ subtr_s[WIDTH]));
    end

    assign rem_o = q_bit_o ? diff_s : shifted_s[WIDTH-1:0];

endmodule

// File: rtl/div32_seq.sv
// Iterative 32-bit signed/unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_EARLY_EXIT_EN skips iteration when |A| < |B|.
module div32_seq
    import div32_seq_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic        clk_i,
    input  logic        rst_i,
    div32_seq_if.slave  bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sgn_q, sgn_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   q_out_q, q_out_d;
    logic [WIDTH-1:0]   r_out_q, r_out_d;
    logic               dz_out_q, dz_out_d;
    logic [WIDTH-1:0]   step_rem_s;
    logic               step_qbit_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s;

    // The dividend register doubles as the quotient: its MSB feeds the step, the new bit enters at the LSB.
    div32_seq_div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[WIDTH-1]),
        .dsr_i     (dsr_q),
        .rem_o     (step_rem_s),
        .q_bit_o   (step_qbit_s)
    );

    assign mag_a_s = (bus.signed_mode && bus.a[WIDTH-1]) ? twoscomp32(bus.a) : bus.a;
    assign mag_b_s = (bus.signed_mode && bus.b[WIDTH-1]) ? twoscomp32(bus.b) : bus.b;

    // Next-state and datapath update for IDLE/CALC/FIX.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sgn_d    = sgn_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        q_out_d  = q_out_q;
        r_out_d  = r_out_q;
        dz_out_d = dz_out_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sgn_d  = bus.signed_mode;
                    sa_d   = bus.a[WIDTH-1];
                    sb_d   = bus.b[WIDTH-1];
                    dvd_d  = mag_a_s;
                    dsr_d  = mag_b_s;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (bus.b == '0) begin
                        // Divide-by-zero returns the raw dividend as remainder.
                        dz_d    = 1'b1;
                        rem_d   = bus.a;
                        state_d = ST_FIX;
                    end else begin
                        dz_d    = 1'b0;
                        rem_d   = '0;
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
`ifdef DIV_EARLY_EXIT_EN
                if ((cnt_q == '0) && (dvd_q < dsr_q)) begin
                    rem_d   = dvd_q;
                    dvd_d   = '0;
                    state_d = ST_FIX;
                end else begin
                    rem_d = step_rem_s;
                    dvd_d = {dvd_q[WIDTH-2:0], step_qbit_s};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
`else
                rem_d = step_rem_s;
                dvd_d = {dvd_q[WIDTH-2:0], step_qbit_s};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_CALC;
                end
`endif
            end
            ST_FIX: begin
                if (dz_q) begin
                    q_out_d = DIV_ZERO_Q;
                    r_out_d = rem_q;
                end else begin
                    q_out_d = (sgn_q && (sa_q != sb_q)) ? twoscomp32(dvd_q) : dvd_q;
                    r_out_d = (sgn_q && sa_q) ? twoscomp32(rem_q) : rem_q;
                end
                dz_out_d = dz_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, working and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sgn_q    <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            q_out_q  <= '0;
            r_out_q  <= '0;
            dz_out_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sgn_q    <= sgn_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            q_out_q  <= q_out_d;
            r_out_q  <= r_out_d;
            dz_out_q <= dz_out_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.q        = q_out_q;
    assign bus.r        = r_out_q;
    assign bus.div_zero = dz_out_q;

endmodule
